imem_loader: RTL and testbench

//  Host-side writer for the instruction memory, which the core only reads via the PC address.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 34 +++
 rtl/imem_word_packer.sv | 44 ++++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IMEM_DEPTH     = 64;
  localparam int unsigned IMEM_ADDR_W    = 6;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * 8;
  localparam int unsigned BYTE_IDX_W     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3
  } ldr_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, load control/status and imem write port of the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = WORD_W
);

  logic              load_start;
  logic [ADDR_W:0]   load_count;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  // Host side: issues loads and streams bytes.
  modport master (
    output load_start, load_count, in_valid, in_byte,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err
  );

  // Loader side.
  modport slave (
    input  load_start, load_count, in_valid, in_byte,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err
  );

endinterface

// File: rtl/imem_word_packer.sv
// Collects bytes little-endian into one instruction word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        in_byte,
  output logic [WORD_W-1:0] word,
  output logic              last_byte
);

  logic [WORD_W-1:0]     pack_d, pack_q;
  logic [BYTE_IDX_W-1:0] byte_idx_d, byte_idx_q;

  // Insert the accepted byte at the current lane and advance the lane.
  always_comb begin
    pack_d     = pack_q;
    byte_idx_d = byte_idx_q;
    if (clr) begin
      pack_d     = '0;
      byte_idx_d = '0;
    end else if (byte_en) begin
      pack_d[8*byte_idx_q +: 8] = in_byte;
      byte_idx_d                = byte_idx_q + BYTE_IDX_W'(1);
    end
  end

  // Pack register and lane counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      pack_q     <= pack_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign word      = pack_q;
  assign last_byte = (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams host bytes into imem as words and holds the core in reset until loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = WORD_W,
  parameter int unsigned DEPTH  = IMEM_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  ldr_state_t        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [DATA_W-1:0] imem_wdata_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              byte_fire_c;
  logic              count_ok_c;
  logic              last_word_c;
  logic              last_byte;
  logic [WORD_W-1:0] pack_word;
  logic [DATA_W-1:0] wdata_c;

  assign byte_fire_c = bus.in_valid & in_ready_q;
  assign count_ok_c  = (bus.load_count != '0) && (bus.load_count <= CNT_W'(DEPTH));
  assign last_word_c = ({1'b0, word_cnt_q} == (count_q - CNT_W'(1)));

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_q != RECV),
    .byte_en   (byte_fire_c),
    .in_byte   (bus.in_byte),
    .word      (pack_word),
    .last_byte (last_byte)
  );

  // Complete word: the byte arriving now fills the top lane of the packed word.
  always_comb begin
    wdata_c                  = DATA_W'(pack_word);
    wdata_c[DATA_W-8 +: 8]   = bus.in_byte;
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      word_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.load_start) begin
            if (count_ok_c) begin
              count_q     <= bus.load_count;
              word_cnt_q  <= '0;
              cpu_reset_q <= 1'b1;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= RECV;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_fire_c && last_byte) begin
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b1;
            imem_addr_q  <= word_cnt_q;
            imem_wdata_q <= wdata_c;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          if (last_word_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            word_cnt_q <= word_cnt_q + ADDR_W'(1);
            in_ready_q <= 1'b1;
            state_q    <= RECV;
          end
        end
        DONE: begin
          cpu_reset_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: word packing, handshake stalls, rejects, full depth, mid-load reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  imem_loader #(.ADDR_W(6), .DATA_W(32), .DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [5:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [31:0] prog[64];

  // Record imem writes and status pulses mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      log_addr.push_back(bus.imem_addr);
      log_data.push_back(bus.imem_wdata);
    end
    if (bus.done) done_cnt++;
    if (bus.err)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int n);
    bus.load_start = 1'b1;
    bus.load_count = 7'(n);
    tick();
    bus.load_start = 1'b0;
  endtask

  // Offer one byte (optionally after an idle host cycle) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    if (gap) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) chk("in_ready_timeout", 32'(guard), 32'(0));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input int n, input bit gaps);
    int d0;
    int guard;
    d0 = done_cnt;
    start_load(n);
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++)
        send_byte(prog[w][8*b +: 8], gaps && !(w == 0 && b == 0));
    guard = 0;
    while (done_cnt == d0 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'(1));
  endtask

  initial begin
    int base;
    int bad;
    int d0;
    bus.load_start = 1'b0;
    bus.load_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_byte    = '0;

    // 1: reset values
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'(1));
    chk("rst_in_ready",  32'(bus.in_ready),  32'(0));
    chk("rst_imem_we",   32'(bus.imem_we),   32'(0));
    chk("rst_busy",      32'(bus.busy),      32'(0));
    chk("rst_done",      32'(bus.done),      32'(0));
    chk("rst_addr",      32'(bus.imem_addr), 32'(0));
    chk("rst_wdata",     bus.imem_wdata,     32'h0);

    // 2: single word, valid held high, cycle-exact timing
    base = log_addr.size();
    start_load(1);
    chk("t2_busy",     32'(bus.busy),      32'(1));
    chk("t2_in_ready", 32'(bus.in_ready),  32'(1));
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    chk("t2_we",       32'(bus.imem_we),   32'(1));
    chk("t2_addr",     32'(bus.imem_addr), 32'(0));
    chk("t2_wdata",    bus.imem_wdata,     32'h12345678);
    chk("t2_rdy_wr",   32'(bus.in_ready),  32'(0));
    tick();
    chk("t2_done",     32'(bus.done),      32'(1));
    chk("t2_we_off",   32'(bus.imem_we),   32'(0));
    chk("t2_cpu_hold", 32'(bus.cpu_reset), 32'(1));
    tick();
    chk("t2_cpu_rel",  32'(bus.cpu_reset), 32'(0));
    chk("t2_done_off", 32'(bus.done),      32'(0));
    chk("t2_nwrites",  32'(log_addr.size() - base), 32'(1));

    // 3: three words with in_valid toggling
    prog[0] = 32'hA1B2C3D4;
    prog[1] = 32'h0BADF00D;
    prog[2] = 32'hCAFEBABE;
    base = log_addr.size();
    run_load("t3", 3, 1'b1);
    chk("t3_nwrites", 32'(log_addr.size() - base), 32'(3));
    for (int i = 0; i < 3; i++) begin
      if (base + i < log_addr.size()) begin
        chk($sformatf("t3_addr%0d", i), 32'(log_addr[base+i]), 32'(i));
        chk($sformatf("t3_data%0d", i), log_data[base+i], prog[i]);
      end
    end
    chk("t3_cpu_rel", 32'(bus.cpu_reset), 32'(0));

    // 4: rejected counts 0 and 65
    base = log_addr.size();
    d0 = err_cnt;
    start_load(0);
    chk("t4_err0",      32'(bus.err),       32'(1));
    chk("t4_busy0",     32'(bus.busy),      32'(0));
    chk("t4_cpu0",      32'(bus.cpu_reset), 32'(0));
    tick();
    chk("t4_err0_off",  32'(bus.err),       32'(0));
    start_load(65);
    chk("t4_err65",     32'(bus.err),       32'(1));
    chk("t4_rdy65",     32'(bus.in_ready),  32'(0));
    chk("t4_cpu65",     32'(bus.cpu_reset), 32'(0));
    tick();
    chk("t4_err_pulses", 32'(err_cnt - d0), 32'(2));
    chk("t4_no_write",  32'(log_addr.size() - base), 32'(0));

    // 5: full depth
    for (int i = 0; i < 64; i++)
      prog[i] = {8'(i), 8'(8'hA5 ^ 8'(i)), 8'(i * 3), 8'(255 - i)};
    base = log_addr.size();
    run_load("t5", 64, 1'b0);
    chk("t5_nwrites", 32'(log_addr.size() - base), 32'(64));
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (base + i >= log_addr.size() || log_addr[base+i] != 6'(i) || log_data[base+i] != prog[i])
        bad++;
    chk("t5_map_errs", 32'(bad), 32'(0));
    if (log_addr.size() > 0)
      chk("t5_last_addr", 32'(log_addr[log_addr.size()-1]), 32'(63));
    chk("t5_busy", 32'(bus.busy), 32'(0));
    chk("t5_cpu_rel", 32'(bus.cpu_reset), 32'(0));

    // 6: reset after two bytes of word 1, then a fresh load
    prog[0] = 32'h11223344;
    prog[1] = 32'h55667788;
    base = log_addr.size();
    d0 = done_cnt;
    start_load(2);
    for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8], 1'b0);
    send_byte(prog[1][7:0], 1'b0);
    send_byte(prog[1][15:8], 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_cpu_reset", 32'(bus.cpu_reset), 32'(1));
    chk("t6_busy",      32'(bus.busy),      32'(0));
    chk("t6_in_ready",  32'(bus.in_ready),  32'(0));
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hEE;
    repeat (8) tick();
    bus.in_valid = 1'b0;
    chk("t6_nwrites", 32'(log_addr.size() - base), 32'(1));
    if (log_addr.size() > base) begin
      chk("t6_w0_addr", 32'(log_addr[base]), 32'(0));
      chk("t6_w0_data", log_data[base],      32'h11223344);
    end
    chk("t6_no_done", 32'(done_cnt - d0), 32'(0));
    chk("t6_cpu_held", 32'(bus.cpu_reset), 32'(1));
    prog[0] = 32'hDEADBEEF;
    base = log_addr.size();
    run_load("t6_fresh", 1, 1'b0);
    chk("t6_fresh_n", 32'(log_addr.size() - base), 32'(1));
    if (log_addr.size() > base) begin
      chk("t6_fresh_addr", 32'(log_addr[base]), 32'(0));
      chk("t6_fresh_data", log_data[base],      32'hDEADBEEF);
    end
    chk("t6_cpu_rel", 32'(bus.cpu_reset), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if the bench itself stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
